// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
//
// Contents:
//   DEF_WIDTH / DEF_DEPTH : default word width and entry count
//   clog2()               : ceiling log2, usable in parameter expressions
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Ceiling log2. clog2(1) = 0, clog2(2) = 1, clog2(5) = 3, clog2(16) = 4.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/param_sdp_ram.sv
// Simple dual-port storage array: one write port, one registered read port.
// Latency: read data appears one clock after rd_en is sampled high.
// Backpressure: none; the owner guarantees addresses are in range.
//
// Ports:
//   clk                        : clock, all activity on posedge
//   wr_en / wr_addr / wr_data  : write port
//   rd_en / rd_addr / rd_data  : read port, rd_data holds until the next rd_en
// Contents are deliberately not reset. A read and write to the same address
// in one cycle returns the old word, which the FIFO relies on when full.
module param_sdp_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            r_rd_q <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with arbitrary depth, occupancy count and sticky error flags.
// Latency: popped word is presented with rd_valid one clock after the read is accepted.
// Backpressure: writes rejected when full unless a read is accepted the same cycle;
//               reads rejected when empty (no fall-through); rejections set sticky flags.
//
// Ports:
//   clk, rst                  : clock and synchronous active-high reset
//   wr_en, wr_data            : write request and word
//   rd_en                     : read request
//   rd_data, rd_valid         : popped word and its one-cycle valid strobe
//   full, empty               : occupancy == DEPTH / == 0
//   almost_full, almost_empty : count >= AF_LEVEL / count <= AE_LEVEL
//   count                     : occupancy 0..DEPTH
//   overflow, underflow       : sticky, set by a rejected write / read
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = 2,
    localparam int CW       = clog2(DEPTH + 1),
    localparam int AW       = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_rd_valid;
    logic             r_have_data;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [WIDTH-1:0] w_ram_q;

    // Flags depend only on the registered count, so there is no
    // combinational path from the request inputs to the status outputs.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Reset dominates: requests during reset are neither accepted nor
    // counted as errors. A read may only use an entry already present,
    // which is what rules out fall-through on an empty FIFO. A write
    // into a full FIFO is allowed when a read frees a slot that cycle.
    assign w_rd_acc = !rst && rd_en && !w_empty;
    assign w_wr_acc = !rst && wr_en && (!w_full || w_rd_acc);

    param_sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wr_ptr),
        .wr_data (wr_data),
        .rd_en   (w_rd_acc),
        .rd_addr (r_rd_ptr),
        .rd_data (w_ram_q)
    );

    // Pointer and occupancy state. Pointers wrap explicitly at DEPTH-1 so
    // non-power-of-two depths never address past the last entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + AW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Read-side strobe. r_have_data records that the RAM output register
    // holds a genuinely popped word; until then (and after any reset) the
    // visible read data is forced to zero because the RAM itself is not
    // reset and its output register may hold stale contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid  <= 1'b0;
            r_have_data <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_have_data <= 1'b1;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign rd_data      = r_have_data ? w_ram_q : '0;
    assign rd_valid     = r_rd_valid;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (32'(r_count) >= AF_LEVEL);
    assign almost_empty = (32'(r_count) <= AE_LEVEL);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- DUT A: WIDTH=8, DEPTH=4 (AF=2, AE=2) ----------------
    logic       a_rst = 1'b0, a_wr_en = 1'b0, a_rd_en = 1'b0;
    logic [7:0] a_wr_data = 8'h00;
    logic [7:0] a_rd_data;
    logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [2:0] a_count;
    logic [6:0] a_stat;
    assign a_stat = {a_full, a_empty, a_af, a_ae, a_ovf, a_unf, a_rd_valid};

    param_sync_fifo #(.WIDTH(8), .DEPTH(4)) dut_a (
        .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_data(a_wr_data), .rd_en(a_rd_en),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_unf)
    );

    // ---------------- DUT B: WIDTH=8, DEPTH=5 (AF=3, AE=2) ----------------
    logic       b_rst = 1'b0, b_wr_en = 1'b0, b_rd_en = 1'b0;
    logic [7:0] b_wr_data = 8'h00;
    logic [7:0] b_rd_data;
    logic       b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0] b_count;
    logic [6:0] b_stat;
    assign b_stat = {b_full, b_empty, b_af, b_ae, b_ovf, b_unf, b_rd_valid};

    param_sync_fifo #(.WIDTH(8), .DEPTH(5)) dut_b (
        .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_data(b_wr_data), .rd_en(b_rd_en),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf)
    );

    // One clock of stimulus; outputs are stable #1 after the edge on return.
    task automatic a_cycle(input logic wr, input logic [7:0] wd, input logic rd, input logic r);
        a_rst = r; a_wr_en = wr; a_wr_data = wd; a_rd_en = rd;
        @(posedge clk); #1;
        a_rst = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
    endtask

    task automatic b_cycle(input logic wr, input logic [7:0] wd, input logic rd, input logic r);
        b_rst = r; b_wr_en = wr; b_wr_data = wd; b_rd_en = rd;
        @(posedge clk); #1;
        b_rst = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
    endtask

    // Status vector order: {full, empty, almost_full, almost_empty, overflow, underflow, rd_valid}
    task automatic test_reset;
        a_cycle(1'b1, 8'hEE, 1'b1, 1'b1);
        checks++;
        if (a_stat !== 7'b0101000) begin
            errors++; $display("FAIL reset_status got %b exp %b", a_stat, 7'b0101000);
        end
        checks++;
        if (a_count !== 3'd0) begin
            errors++; $display("FAIL reset_count got %0d exp 0", a_count);
        end
        checks++;
        if (a_rd_data !== 8'h00) begin
            errors++; $display("FAIL reset_rd_data got %h exp 00", a_rd_data);
        end
    endtask

    task automatic test_fill;
        logic [7:0] vals [4]     = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [6:0] exp_stat [4] = '{7'b0001000, 7'b0011000, 7'b0010000, 7'b1010000};
        for (int i = 0; i < 4; i++) begin
            a_cycle(1'b1, vals[i], 1'b0, 1'b0);
            checks++;
            if (a_count !== 3'(i + 1)) begin
                errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, a_count, i + 1);
            end
            checks++;
            if (a_stat !== exp_stat[i]) begin
                errors++; $display("FAIL fill_status[%0d] got %b exp %b", i, a_stat, exp_stat[i]);
            end
        end
        a_cycle(1'b1, 8'h55, 1'b0, 1'b0);
        checks++;
        if (a_stat !== 7'b1010100) begin
            errors++; $display("FAIL overflow_status got %b exp %b", a_stat, 7'b1010100);
        end
        checks++;
        if (a_count !== 3'd4) begin
            errors++; $display("FAIL overflow_count got %0d exp 4", a_count);
        end
    endtask

    task automatic test_drain;
        logic [7:0] exp_dat [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [6:0] exp_stat [4] = '{7'b0010101, 7'b0011101, 7'b0001101, 7'b0101101};
        for (int i = 0; i < 4; i++) begin
            a_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (a_rd_data !== exp_dat[i]) begin
                errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, a_rd_data, exp_dat[i]);
            end
            checks++;
            if (a_stat !== exp_stat[i]) begin
                errors++; $display("FAIL drain_status[%0d] got %b exp %b", i, a_stat, exp_stat[i]);
            end
        end
        a_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (a_stat !== 7'b0101110) begin
            errors++; $display("FAIL underflow_status got %b exp %b", a_stat, 7'b0101110);
        end
        checks++;
        if (a_rd_data !== 8'h44) begin
            errors++; $display("FAIL underflow_hold_data got %h exp 44", a_rd_data);
        end
    endtask

    task automatic test_full_rw;
        logic [7:0] exp_dat [4] = '{8'h02, 8'h03, 8'h04, 8'hAA};
        a_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) a_cycle(1'b1, 8'(i), 1'b0, 1'b0);
        a_cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        checks++;
        if (a_stat !== 7'b1010001) begin
            errors++; $display("FAIL full_rw_status got %b exp %b", a_stat, 7'b1010001);
        end
        checks++;
        if (a_count !== 3'd4 || a_rd_data !== 8'h01) begin
            errors++; $display("FAIL full_rw_count_data got %0d/%h exp 4/01", a_count, a_rd_data);
        end
        for (int i = 0; i < 4; i++) begin
            a_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (a_rd_data !== exp_dat[i] || a_rd_valid !== 1'b1 || a_count !== 3'(3 - i)) begin
                errors++;
                $display("FAIL full_rw_drain[%0d] got %h/%b/%0d exp %h/1/%0d",
                         i, a_rd_data, a_rd_valid, a_count, exp_dat[i], 3 - i);
            end
        end
    endtask

    task automatic test_empty_rw;
        a_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        a_cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        checks++;
        if (a_stat !== 7'b0001010) begin
            errors++; $display("FAIL empty_rw_status got %b exp %b", a_stat, 7'b0001010);
        end
        checks++;
        if (a_count !== 3'd1) begin
            errors++; $display("FAIL empty_rw_count got %0d exp 1", a_count);
        end
        a_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (a_rd_data !== 8'h5A || a_rd_valid !== 1'b1 || a_count !== 3'd0) begin
            errors++;
            $display("FAIL empty_rw_read got %h/%b/%0d exp 5a/1/0", a_rd_data, a_rd_valid, a_count);
        end
    endtask

    task automatic test_reset_mid;
        a_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) a_cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        a_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (a_count !== 3'd3 || a_rd_valid !== 1'b1 || a_rd_data !== 8'h61) begin
            errors++;
            $display("FAIL mid_pre got %0d/%b/%h exp 3/1/61", a_count, a_rd_valid, a_rd_data);
        end
        a_cycle(1'b1, 8'h99, 1'b1, 1'b1);
        checks++;
        if (a_stat !== 7'b0101000) begin
            errors++; $display("FAIL mid_reset_status got %b exp %b", a_stat, 7'b0101000);
        end
        checks++;
        if (a_count !== 3'd0 || a_rd_data !== 8'h00) begin
            errors++; $display("FAIL mid_reset_count_data got %0d/%h exp 0/00", a_count, a_rd_data);
        end
        a_cycle(1'b1, 8'h77, 1'b0, 1'b0);
        a_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (a_rd_data !== 8'h77 || a_rd_valid !== 1'b1 || a_count !== 3'd0) begin
            errors++;
            $display("FAIL mid_after got %h/%b/%0d exp 77/1/0", a_rd_data, a_rd_valid, a_count);
        end
    endtask

    task automatic test_wrap;
        b_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            b_cycle(1'b1, 8'(i), 1'b0, 1'b0);
            checks++;
            if (b_count !== 3'(i + 1)) begin
                errors++; $display("FAIL wrap_fill_count[%0d] got %0d exp %0d", i, b_count, i + 1);
            end
        end
        checks++;
        if (b_full !== 1'b1) begin
            errors++; $display("FAIL wrap_full got %b exp 1", b_full);
        end
        for (int i = 5; i < 12; i++) begin
            b_cycle(1'b1, 8'(i), 1'b1, 1'b0);
            checks++;
            if (b_rd_data !== 8'(i - 5) || b_rd_valid !== 1'b1 || b_count !== 3'd5) begin
                errors++;
                $display("FAIL wrap_rw[%0d] got %h/%b/%0d exp %h/1/5",
                         i, b_rd_data, b_rd_valid, b_count, 8'(i - 5));
            end
        end
        for (int i = 7; i < 12; i++) begin
            b_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (b_rd_data !== 8'(i) || b_rd_valid !== 1'b1 || b_count !== 3'(11 - i)) begin
                errors++;
                $display("FAIL wrap_drain[%0d] got %h/%b/%0d exp %h/1/%0d",
                         i, b_rd_data, b_rd_valid, b_count, 8'(i), 11 - i);
            end
        end
        checks++;
        if (b_stat !== 7'b0101001) begin
            errors++; $display("FAIL wrap_final_status got %b exp %b", b_stat, 7'b0101001);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_empty_rw();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of storage entries (>=2, any integer, not only power of two).
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full asserted when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2, almost_empty asserted when count <= AE_LEVEL.
REQ-005 Localparam CW = clog2(DEPTH+1), count width; AW = clog2(DEPTH), pointer width.
REQ-006 clk  input  1  single clock; all state updates on posedge clk.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_data  input  WIDTH  write word.
REQ-010 rd_en  input  1  read request.
REQ-011 rd_data  output  WIDTH  registered read word.
REQ-012 rd_valid  output  1  rd_data holds a newly popped word this cycle.
REQ-013 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 count  output  CW  current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write accepted (wr_acc) when wr_en && (!full || rd_acc); word stored at wr_ptr, wr_ptr advances.
REQ-017 Read accepted (rd_acc) when rd_en && !empty; word at rd_ptr is registered into rd_data next edge, rd_ptr advances.
REQ-018 Read latency exactly 1 cycle: rd_valid high in the cycle after rd_acc, low otherwise; rd_data holds last popped value when rd_valid low.
REQ-019 No fall-through: a read request while empty is rejected even if a write is accepted the same cycle.
REQ-020 Simultaneous wr_acc and rd_acc: count unchanged; when full both accepted, full stays high.
REQ-021 Count: +1 on wr_acc only, -1 on rd_acc only, unchanged otherwise; never exceeds DEPTH or goes below 0.
REQ-022 Pointers wrap from DEPTH-1 to 0 for any DEPTH, including non-power-of-two.
REQ-023 full = (count == DEPTH); empty = (count == 0); almost flags per REQ-003/004; all flags registered-derived from count, no combinational path from wr_en/rd_en.
REQ-024 overflow sets when wr_en && !wr_acc; underflow sets when rd_en && !rd_acc; both stay set until rst.
REQ-025 Rejected requests leave memory, pointers, count unchanged.

Reset
REQ-026 On rst high at posedge clk: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0; empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
REQ-027 rst dominates wr_en/rd_en in the same cycle; requests during reset are discarded and do not set error flags.
REQ-028 Storage contents not cleared by reset; contents are unobservable until rewritten.
REQ-029 Reset mid-operation discards all stored words; a rd_valid pending from the previous cycle is suppressed.

Structure
REQ-030 Shared package fifo_pkg holds clog2 function and default WIDTH/DEPTH constants.
REQ-031 Storage is one sub-module param_sdp_ram (simple dual-port, one write port, one registered read port, WIDTH x DEPTH, no reset).
REQ-032 Control (pointers, count, flags, error bits) lives in param_sync_fifo itself.

Verification
REQ-033 WIDTH=8, DEPTH=4: write 0x11,0x22,0x33,0x44 -> full=1, count=4; fifth write 0x55 -> overflow=1, contents unchanged.
REQ-034 From full, read 4 times -> rd_data 0x11,0x22,0x33,0x44 each one cycle after rd_en with rd_valid=1; then empty=1; extra read -> underflow=1, rd_valid=0.
REQ-035 DEPTH=5: 12 writes interleaved with reads, values 0..11 -> output order 0..11, pointer wrap correct, count never >5.
REQ-036 Full, wr_en and rd_en same cycle with 0xAA -> both accepted, count stays 4, 0xAA read out last.
REQ-037 Empty, wr_en and rd_en same cycle -> write accepted, read rejected, underflow=1, count=1.
REQ-038 Count=3 with rst asserted alongside wr_en -> next cycle count=0, empty=1, overflow=0, rd_valid=0.
